// File: rtl/acc_sched.sv
// rtl/acc_sched.sv - two-requester round-robin accelerator job scheduler
//
// Purpose: arbitrates two requesters for one accelerator core, sequences a
// job through GRANT/RUN/DONE/ABORT, counts RUN cycles and aborts on timeout.
//
// Ports:
//   HCLK, HRESET     clock, synchronous active-high reset
//   req_i[1:0]       per-requester request level
//   go_i[1:0]        per-requester start strobe (only owner's bit honoured)
//   gnt_o[1:0]       registered one-hot grant, zero when no owner
//   done_o[1:0]      one-cycle completion pulse to owner
//   err_o[1:0]       one-cycle timeout-abort pulse to owner
//   busy_o           high whenever not idle
//   cycles_o         RUN cycle count of the last completed job
//   acc_start_o      start level to accelerator core (high in RUN)
//   acc_done_i       done level from accelerator core
module acc_sched #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [1:0]       req_i,
  input  logic [1:0]       go_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [1:0]       err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             acc_start_o,
  input  logic             acc_done_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  // Index of the requester granted most recently; the other one wins a tie.
  logic             ptr_q, ptr_d;
  logic             win;
  logic             owner_req;
  logic             owner_go;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    ptr_d     = ptr_q;
    win       = 1'b0;
    owner_req = |(req_i & gnt_q);
    owner_go  = |(go_i & gnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          win     = (req_i == 2'b11) ? ~ptr_q : req_i[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          ptr_d   = win;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A stale done level from the previous job blocks the start.
        if (owner_go && !acc_done_i) begin
          cnt_d   = CNT_ONE;
          state_d = S_RUN;
        end else if (!owner_req) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (acc_done_i) begin
          cycles_d = cnt_q;
          done_d   = gnt_q;
          state_d  = S_DONE;
        end else if (cnt_q == TIMEOUT_VAL) begin
          err_d    = gnt_q;
          state_d  = S_ABORT;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (!acc_done_i) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      cnt_q    <= '0;
      cycles_q <= '0;
      ptr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign cycles_o    = cycles_q;
  assign acc_start_o = (state_q == S_RUN);

endmodule
